seg7_scan_decoder: RTL and testbench

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

---
 rtl/seg7_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed, active-low 7-segment scan bus back into committed hex digits.
// Optional two-flop input synchronizer enabled by defining SEG7DEC_SYNC_EN.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CNT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  SEG,
   input  logic [3:0]  AN,
   output logic [15:0] value,
   output logic [3:0]  dig_valid,
   output logic        upd,
   output logic        err
);

   localparam logic [3:0] LP_STABLE = 4'(STABLE_CNT);

   logic [6:0]  w_seg;
   logic [3:0]  w_an;

`ifdef SEG7DEC_SYNC_EN
   logic [6:0]  r_seg_s1, r_seg_s2;
   logic [3:0]  r_an_s1, r_an_s2;

   // Idle values keep the decoder quiet until real samples arrive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg_s1 <= 7'h7F;
         r_seg_s2 <= 7'h7F;
         r_an_s1  <= 4'hF;
         r_an_s2  <= 4'hF;
      end else begin
         r_seg_s1 <= SEG;
         r_seg_s2 <= r_seg_s1;
         r_an_s1  <= AN;
         r_an_s2  <= r_an_s1;
      end
   end

   assign w_seg = r_seg_s2;
   assign w_an  = r_an_s2;
`else
   assign w_seg = SEG;
   assign w_an  = AN;
`endif

   logic [1:0]  r_cand_dig;
   logic [4:0]  r_cand_sym;
   logic [3:0]  r_cnt;
   logic [15:0] r_value;
   logic [3:0]  r_dig_valid;
   logic        r_upd;
   logic        r_err;

   logic        w_an_idle;
   logic        w_an_onehot;
   logic [1:0]  w_dig;
   logic        w_sym_ok;
   logic [4:0]  w_sym;
   logic        w_legal;
   logic        w_bad;
   logic        w_same;
   logic        w_commit;
   logic [1:0]  w_cand_dig_nx;
   logic [4:0]  w_cand_sym_nx;
   logic [3:0]  w_cnt_nx;
   logic [15:0] w_value_nx;
   logic [3:0]  w_dig_valid_nx;
   logic        w_upd_nx;

   always_comb begin
      w_an_onehot = 1'b1;
      w_dig       = 2'd0;
      case (w_an)
         4'b1110: w_dig = 2'd0;
         4'b1101: w_dig = 2'd1;
         4'b1011: w_dig = 2'd2;
         4'b0111: w_dig = 2'd3;
         default: w_an_onehot = 1'b0;
      endcase
   end

   // w_sym[4] marks BLANK; w_sym[3:0] is the hex nibble otherwise.
   always_comb begin
      w_sym_ok = 1'b1;
      w_sym    = 5'h00;
      case (w_seg)
         7'b1000000: w_sym = 5'h00;
         7'b1111001: w_sym = 5'h01;
         7'b0100100: w_sym = 5'h02;
         7'b0110000: w_sym = 5'h03;
         7'b0011001: w_sym = 5'h04;
         7'b0010010: w_sym = 5'h05;
         7'b0000010: w_sym = 5'h06;
         7'b1111000: w_sym = 5'h07;
         7'b0000000: w_sym = 5'h08;
         7'b0010000: w_sym = 5'h09;
         7'b0001000: w_sym = 5'h0A;
         7'b0000011: w_sym = 5'h0B;
         7'b1000110: w_sym = 5'h0C;
         7'b0100001: w_sym = 5'h0D;
         7'b0000110: w_sym = 5'h0E;
         7'b0001110: w_sym = 5'h0F;
         7'b1111111: w_sym = 5'h10;
         default:    w_sym_ok = 1'b0;
      endcase
   end

   assign w_an_idle = (w_an == 4'hF);
   assign w_legal   = w_an_onehot && w_sym_ok;
   assign w_bad     = !w_an_idle && !w_legal;
   // A zero run count means there is no candidate.
   assign w_same    = (r_cnt != 4'd0) && (w_dig == r_cand_dig) && (w_sym == r_cand_sym);

   always_comb begin
      w_cand_dig_nx  = r_cand_dig;
      w_cand_sym_nx  = r_cand_sym;
      w_cnt_nx       = r_cnt;
      w_commit       = 1'b0;
      w_value_nx     = r_value;
      w_dig_valid_nx = r_dig_valid;
      w_upd_nx       = 1'b0;

      if (w_bad) begin
         w_cand_dig_nx = 2'd0;
         w_cand_sym_nx = 5'h00;
         w_cnt_nx      = 4'd0;
      end else if (w_legal) begin
         if (w_same) begin
            w_cnt_nx = (r_cnt >= LP_STABLE) ? r_cnt : r_cnt + 4'd1;
         end else begin
            w_cand_dig_nx = w_dig;
            w_cand_sym_nx = w_sym;
            w_cnt_nx      = 4'd1;
         end
         // Commit only on the transition into the stable count, never on saturated repeats.
         w_commit = (w_cnt_nx == LP_STABLE) && !(w_same && (r_cnt == LP_STABLE));
      end

      if (w_commit) begin
         if (w_sym[4]) begin
            w_dig_valid_nx[w_dig] = 1'b0;
         end else begin
            w_value_nx[{w_dig, 2'b00} +: 4] = w_sym[3:0];
            w_dig_valid_nx[w_dig]           = 1'b1;
         end
         w_upd_nx = (w_value_nx != r_value) || (w_dig_valid_nx != r_dig_valid);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cand_dig  <= 2'd0;
         r_cand_sym  <= 5'h00;
         r_cnt       <= 4'd0;
         r_value     <= 16'h0000;
         r_dig_valid <= 4'b0000;
         r_upd       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_cand_dig  <= w_cand_dig_nx;
         r_cand_sym  <= w_cand_sym_nx;
         r_cnt       <= w_cnt_nx;
         r_value     <= w_value_nx;
         r_dig_valid <= w_dig_valid_nx;
         r_upd       <= w_upd_nx;
         r_err       <= w_bad;
      end
   end

   assign value     = r_value;
   assign dig_valid = r_dig_valid;
   assign upd       = r_upd;
   assign err       = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (STABLE_CNT=4); picks the sync-latency
// sequence when SEG7DEC_SYNC_EN is defined.
module tb_seg7_scan_decoder;

   logic        clk;
   logic        rst;
   logic [6:0]  SEG;
   logic [3:0]  AN;
   logic [15:0] value;
   logic [3:0]  dig_valid;
   logic        upd;
   logic        err;

   int n_checks = 0;
   int n_errors = 0;
   int upd_sum;

   localparam logic [6:0] S_1 = 7'b1111001;
   localparam logic [6:0] S_2 = 7'b0100100;
   localparam logic [6:0] S_5 = 7'b0010010;
   localparam logic [6:0] S_7 = 7'b1111000;
   localparam logic [6:0] S_A = 7'b0001000;
   localparam logic [6:0] S_B = 7'b0000011;
   localparam logic [6:0] S_BL = 7'b1111111;
   localparam logic [6:0] S_BAD = 7'b1010101;

   seg7_scan_decoder #(.STABLE_CNT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .SEG       (SEG),
      .AN        (AN),
      .value     (value),
      .dig_valid (dig_valid),
      .upd       (upd),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [6:0] seg, input logic [3:0] an, input int n);
      for (int i = 0; i < n; i++) begin
         SEG = seg;
         AN  = an;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_state(input string tag, input logic [15:0] v, input logic [3:0] dv,
                              input logic u, input logic e);
      check_eq({tag, ".value"}, value, v);
      check_eq({tag, ".dig_valid"}, {12'h0, dig_valid}, {12'h0, dv});
      check_eq({tag, ".upd"}, {15'h0, upd}, {15'h0, u});
      check_eq({tag, ".err"}, {15'h0, err}, {15'h0, e});
   endtask

   initial begin
      rst = 1'b1;
      SEG = 7'h7F;
      AN  = 4'hF;
      #1;
      check_state("reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      step(7'h7F, 4'hF, 0);
      rst = 1'b0;

`ifdef SEG7DEC_SYNC_EN
      step(S_2, 4'b1110, 5);
      check_state("sync_edge5", 16'h0000, 4'b0000, 1'b0, 1'b0);
      step(S_2, 4'b1110, 1);
      check_state("sync_edge6", 16'h0002, 4'b0001, 1'b1, 1'b0);
      step(S_2, 4'b1110, 1);
      check_state("sync_edge7", 16'h0002, 4'b0001, 1'b0, 1'b0);
      step(S_2, 4'b1100, 1);
      step(7'h7F, 4'hF, 1);
      check_eq("sync_err_early", {15'h0, err}, 16'h0000);
      step(7'h7F, 4'hF, 1);
      check_state("sync_err", 16'h0002, 4'b0001, 1'b0, 1'b1);
      step(7'h7F, 4'hF, 1);
      check_eq("sync_err_clear", {15'h0, err}, 16'h0000);
`else
      // Basic commit of '2' on digit 0
      step(S_2, 4'b1110, 3);
      check_state("d0_edge3", 16'h0000, 4'b0000, 1'b0, 1'b0);
      step(S_2, 4'b1110, 1);
      check_state("d0_edge4", 16'h0002, 4'b0001, 1'b1, 1'b0);
      step(S_2, 4'b1110, 1);
      check_state("d0_edge5", 16'h0002, 4'b0001, 1'b0, 1'b0);

      // Glitch: A for 3 edges, then B for 4 edges on digit 1
      step(S_A, 4'b1101, 3);
      check_state("glitch_a3", 16'h0002, 4'b0001, 1'b0, 1'b0);
      step(S_B, 4'b1101, 3);
      check_state("glitch_b3", 16'h0002, 4'b0001, 1'b0, 1'b0);
      step(S_B, 4'b1101, 1);
      check_state("glitch_b4", 16'h00B2, 4'b0011, 1'b1, 1'b0);

      // Multiple enables low: err only, committed state untouched
      step(S_B, 4'b1100, 1);
      check_state("multi_an", 16'h00B2, 4'b0011, 1'b0, 1'b1);
      step(7'h7F, 4'hF, 1);
      check_eq("multi_an_clear", {15'h0, err}, 16'h0000);

      // Bad pattern clears a partial run of '7' on digit 3
      step(S_7, 4'b0111, 2);
      step(S_BAD, 4'b0111, 1);
      check_state("bad_seg", 16'h00B2, 4'b0011, 1'b0, 1'b1);
      step(S_7, 4'b0111, 3);
      check_state("after_bad3", 16'h00B2, 4'b0011, 1'b0, 1'b0);
      step(S_7, 4'b0111, 1);
      check_state("after_bad4", 16'h70B2, 4'b1011, 1'b1, 1'b0);

      // Blank on digit 3 with an idle sample in the middle of the run
      step(S_BL, 4'b0111, 2);
      step(S_BL, 4'b1111, 1);
      step(S_BL, 4'b0111, 1);
      check_state("blank3", 16'h70B2, 4'b1011, 1'b0, 1'b0);
      step(S_BL, 4'b0111, 1);
      check_state("blank4", 16'h70B2, 4'b0011, 1'b1, 1'b0);

      // Recommit of an unchanged digit gives no upd
      step(S_2, 4'b1110, 4);
      check_state("same_commit", 16'h70B2, 4'b0011, 1'b0, 1'b0);

      // Saturation: long hold commits once
      step(S_5, 4'b1011, 4);
      check_state("d2_commit", 16'h75B2, 4'b0111, 1'b1, 1'b0);
      upd_sum = 0;
      for (int i = 0; i < 12; i++) begin
         step(S_5, 4'b1011, 1);
         upd_sum += int'(upd);
      end
      check_eq("saturate_no_upd", 16'(upd_sum), 16'h0000);
      check_eq("saturate_value", value, 16'h75B2);

      // Reset mid-run
      step(S_1, 4'b1011, 2);
      rst = 1'b1;
      #1;
      check_state("mid_reset", 16'h0000, 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_state("mid_reset_edge", 16'h0000, 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      step(S_1, 4'b1011, 3);
      check_state("post_reset3", 16'h0000, 4'b0000, 1'b0, 1'b0);
      step(S_1, 4'b1011, 1);
      check_state("post_reset4", 16'h0100, 4'b0100, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
